counter_4bit: RTL and testbench
===============================

# counter_4bit

4-bit synchronous binary up-counter with no enable input. Advances by one on every rising clock edge and wraps from 15 to 0. Serves as a free-running cycle/sequence counter for local timing and test stimulus. All flops share one clock. A single asynchronous active-high reset forces the counter to zero.

## Interface

Reset: one clock; reset is asynchronous and active-high.

Parameters:
- WIDTH, default 4: counter width in bits. Only 4 is required to be verified. The RTL is written generically for WIDTH ≥ 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- count  output  WIDTH  current count value, driven directly from flops.
- tc  output  1  terminal count:
  - combinational;
  - 1 when count == 2^WIDTH−1, else 0;
  - forced 0 while reset is high.
- wrap  output  1  registered one-cycle pulse; 1 in the cycle immediately after count rolls over from max to 0.

## Operation

- Counting:
  - Counter is built as a synchronous T-flop carry chain.
  - Bit 0 toggles every cycle.
  - Bit i toggles when bits 0..i−1 are all 1.
  - All bits update on the same clock edge, so there is no ripple between bits.
- Next-state rule: count_next = (count + 1) mod 2^WIDTH. There is no hold and no enable; the counter advances on every rising edge while reset is low.
- Wrap-around:
  - From 4'b1111 the next edge gives 4'b0000.
  - On that same edge the wrap register is set to 1.
  - wrap returns to 0 on the following edge.
- tc = &count, gated by reset low.
- Reset:
  - While reset is high: count = 0, wrap = 0, tc = 0, regardless of clk.
  - Assertion takes effect immediately, without waiting for a clock edge.
  - Deassertion is sampled as ordinary logic. The first rising edge with reset low moves count from 0 to 1.
- Reset mid-operation: count returns to 0 immediately, whatever its value. A pending wrap pulse is cleared.
- No X propagation: every flop has a reset value. Outputs are defined from the moment reset is first asserted.

## Timing

- Latency: count changes one clk-to-q delay after each rising edge. No combinational path runs from any input to count.
- tc is combinational from count. It is valid in the same cycle that count shows the maximum value (15).
- wrap is high for exactly one cycle, the cycle in which count == 0 after a rollover. It is never high when count is 0 because of reset.
- Period: with count held at 0 after reset, count at edge n (n = 1, 2, ...) equals n mod 16.
- Reset release on a falling clk edge (e.g. at 10 ns with a 10 ns period starting low) produces:
  - count = 1 at the 15 ns edge;
  - count = 15 at 155 ns;
  - count = 0 (with wrap = 1) at 165 ns.
- Reset released coincident with a rising edge: that edge does not increment; counting starts on the next edge.

## Test plan

- Power-up reset: hold reset = 1 for 10 ns with clk running -> count = 0, tc = 0, wrap = 0 throughout, with no X after time 0.
- Free-run sequence: release reset at 10 ns, run 20 rising edges -> count reads 1, 2, ..., 15, 0, 1, 2, 3, 4 on successive edges.
- Wrap flags: across the 15 -> 0 transition:
  - tc = 1 only while count = 15;
  - wrap = 1 only during the cycle where count = 0 after rollover;
  - both are 0 in all other cycles.
- Asynchronous reset mid-count: assert reset between edges when count = 9 -> count = 0 before the next edge. It stays 0 while reset is held, then resumes 1, 2, ... after release.
- Reset during tc: assert reset while count = 15 -> tc drops to 0 immediately, and no wrap pulse follows.
- Long run: 64 edges after reset -> count returns to 0 exactly four times, with four single-cycle wrap pulses and no skipped or repeated values.

Source files
------------

// File: rtl/counter_4bit_if.sv
// Output bundle of the free-running counter: count value plus its
// terminal-count and rollover flags.
interface counter_4bit_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    // The counter drives the bundle.
    modport master (
        output count,
        output tc,
        output wrap
    );

    // Consumers only observe it.
    modport slave (
        input count,
        input tc,
        input wrap
    );
endinterface

// File: rtl/counter_4bit.sv
// Free-running synchronous up-counter built as a T-flop carry chain.
// Every bit updates on the same clock edge; the counter wraps from max to 0.
// It raises a combinational terminal-count flag and a registered wrap pulse.
module counter_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    counter_4bit_if.master cnt_bus
);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_count_next;
    logic             w_carry;
    logic             w_max;

    // Toggle enables: bit i flips when all lower bits are 1 (bit 0 always flips).
    always_comb begin
        w_toggle = '0;
        w_carry  = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_toggle[i] = w_carry;
            w_carry     = w_carry & r_count[i];
        end
    end

    assign w_count_next = r_count ^ w_toggle;
    assign w_max        = &r_count;

    // Count and wrap state; rollover happens exactly on the edge leaving max.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_wrap  <= w_max;
        end
    end

    assign cnt_bus.count = r_count;
    assign cnt_bus.tc    = w_max & ~reset;
    assign cnt_bus.wrap  = r_wrap;

endmodule

// File: tb/tb_counter_4bit.sv
// Self-checking bench for counter_4bit: directed phases followed by randomly
// timed asynchronous resets, all checked against an arithmetic reference model.
module tb_counter_4bit;

    logic clk;
    logic reset;

    counter_4bit_if #(.WIDTH(4)) cif ();

    counter_4bit #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .cnt_bus (cif.master)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: what count/wrap should be right now.
    int exp_count = 0;
    int exp_wrap  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_tc;
        exp_tc = ((exp_count == 15) && (reset == 1'b0)) ? 32'd1 : 32'd0;
        check({tag, ".count"}, {28'd0, cif.count}, exp_count);
        check({tag, ".tc"}, {31'd0, cif.tc}, exp_tc);
        check({tag, ".wrap"}, {31'd0, cif.wrap}, exp_wrap);
    endtask

    // Advance one rising edge in the model, then sample 2 ns later.
    task automatic do_edge(input string tag);
        @(posedge clk);
        if (reset) begin
            exp_count = 0;
            exp_wrap  = 0;
        end else begin
            exp_wrap  = (exp_count == 15) ? 1 : 0;
            exp_count = (exp_count + 1) % 16;
        end
        #2;
        check_all(tag);
    endtask

    // Assert reset between edges; effect must be immediate.
    task automatic async_reset(input string tag);
        #($urandom_range(1, 5));
        reset     = 1'b1;
        exp_count = 0;
        exp_wrap  = 0;
        #1;
        check_all(tag);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t expected < 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_wraps;
        int n_zeros;
        int hold;

        // Power-up reset held through one rising edge.
        reset = 1'b1;
        #1;
        check_all("por_t1");
        do_edge("por_edge");
        release_reset("por_release");

        // Free-run 20 edges: 1..15, 0, 1..4, with tc/wrap around the rollover.
        for (int i = 0; i < 20; i++) do_edge("freerun");

        // Advance to 9, then reset mid-cycle and hold.
        while (exp_count != 9) do_edge("to9");
        async_reset("rst_at9");
        hold = $urandom_range(1, 3);
        for (int i = 0; i < hold; i++) do_edge("rst_hold");
        release_reset("rst9_release");
        for (int i = 0; i < 3; i++) do_edge("resume");

        // Reset while tc is high: tc drops at once and no wrap follows.
        while (exp_count != 15) do_edge("to15");
        async_reset("rst_at15");
        do_edge("rst15_hold");
        release_reset("rst15_release");
        do_edge("after_rst15");

        // Long run from a fresh reset: four rollovers in 64 edges.
        async_reset("long_rst");
        release_reset("long_release");
        n_wraps = 0;
        n_zeros = 0;
        for (int i = 0; i < 64; i++) begin
            do_edge("long");
            if (cif.wrap === 1'b1) n_wraps++;
            if (cif.count === 4'd0) n_zeros++;
        end
        check("long_wraps", n_wraps, 4);
        check("long_zeros", n_zeros, 4);

        // Randomly timed reset pulses mixed with free-running stretches.
        for (int k = 0; k < 40; k++) begin
            int run;
            run = $urandom_range(0, 20);
            for (int i = 0; i < run; i++) do_edge("rand_run");
            if ($urandom_range(0, 3) == 0) begin
                async_reset("rand_rst");
                hold = $urandom_range(0, 2);
                for (int i = 0; i < hold; i++) do_edge("rand_hold");
                release_reset("rand_release");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
